bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the bit-stream pattern detectors. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock, MSB first, on a single-bit line that drives a detector's `in` input. A companion qualifier, `ser_valid`, marks real data bits. Back-to-back words stream with no idle bubble, so a pattern that spans a word boundary is still detected.

## Interface
- `WIDTH`, default 8, data word width; legal range ≥ 2.
- `IDLE_LEVEL`, default 1'b0, value driven on `ser_out` when no bit is being sent.
- `clk`  input  1  clock; all state changes on its rising edge.
- `reset`  input  1  reset, synchronous, active-high.
- `in_data`  input  WIDTH  parallel word; sampled only on accept.
- `in_valid`  input  1  upstream has a word.
- `in_ready`  output  1  block can accept a word this cycle.
- `ser_out`  output  1  serial bit to the detector.
- `ser_valid`  output  1  `ser_out` carries a data bit (or parity bit) this cycle.
- `busy`  output  1  high whenever state ≠ IDLE.

## Operation
- Accept occurs on a rising edge where `in_valid && in_ready`. Data is captured into shift register `shreg`, and bit counter `cnt` is cleared to 0.
- The FSM has states IDLE, SHIFT and PARITY. PARITY exists only with the macro; see Configuration.
- IDLE:
  - `in_ready`=1, `ser_valid`=0, `ser_out`=`IDLE_LEVEL`.
  - Accept → SHIFT.
- SHIFT:
  - `ser_valid`=1 and `ser_out`=`shreg[WIDTH-1]`.
  - Each edge: `shreg` shifts left by 1 with zero fill, and `cnt` increments.
  - Last beat is `cnt`==WIDTH-1:
    - Without parity: `in_ready`=1. Accept → reload `shreg`, set `cnt`=0 and stay in SHIFT; no accept → IDLE.
    - With parity: → PARITY, and `in_ready`=0.
  - On non-last beats, `in_ready`=0.
- PARITY:
  - `ser_valid`=1, `ser_out`=stored parity bit, `in_ready`=1.
  - Accept → SHIFT with the new word; else → IDLE.
- `in_data` is ignored whenever `in_ready`=0. `in_valid` may stay high across a busy period without effect; the word is taken at the next ready cycle.
- `cnt` width is `$clog2(WIDTH)`. It never exceeds WIDTH-1, and no wrap-around is visible outside the block.

## Timing
- Reset values:
  - State is IDLE, `shreg`=0, `cnt`=0, parity bit is 0.
  - `ser_out`=`IDLE_LEVEL`, `ser_valid`=0, `busy`=0.
  - `in_ready`=0 while `reset` is high and 1 on the first cycle after release.
- Reset mid-word aborts immediately. The remaining bits are discarded, and the next cycle shows the IDLE values.
- Latency: for a word accepted at edge N, bit WIDTH-1 appears on `ser_out` in the cycle following edge N. Bit 0 appears WIDTH-1 cycles later.
- Throughput:
  - One word per WIDTH cycles, or WIDTH+1 with parity.
  - With continuous `in_valid`, `ser_valid` stays high with no gaps.
- All outputs are decoded from registered state only; there is no combinational path from the inputs to any output. The exception is `in_ready`, which depends on state and `reset` only.
- Simultaneous `reset` and accept: reset wins and the word is not taken.

## Configuration
- Macro: `BIT_SERIALIZER_PARITY_EN`.
- Defined:
  - An even-parity bit (XOR of all WIDTH data bits, computed from `in_data` at accept and stored) is emitted in the PARITY state after bit 0.
  - The frame is WIDTH+1 bits.
- Undefined:
  - The PARITY state, the parity register and its logic are not compiled.
  - The frame is exactly WIDTH bits, and `in_ready` is asserted on the last data beat.

## Test plan
- Reset, then idle with `in_valid`=0 for 5 cycles → `ser_valid`=0, `ser_out`=`IDLE_LEVEL`, `in_ready`=1 and `busy`=0 throughout.
- WIDTH=8, single accept of 0xB0 → `ser_out` sequence 1,0,1,1,0,0,0,0 on 8 consecutive `ser_valid` cycles, then IDLE. A downstream 1011 detector fires exactly once.
- Back-to-back words 0x0B then 0xC5, with `in_valid` held → 16 contiguous `ser_valid` cycles with bits 00001011 11000101. Each word's accept coincides with the prior word's last beat.
- `in_valid` high with changing `in_data` during SHIFT → `in_data` changes are ignored. The value present at the ready cycle is the one captured.
- Assert `reset` for 1 cycle at bit 3 of 0xFF → the next cycle shows `ser_valid`=0 and `in_ready`=1, and no further bits of 0xFF are emitted.
- With `BIT_SERIALIZER_PARITY_EN` defined:
  - 0x07 → 9 bits 00000111 followed by parity 1.
  - 0x03 → parity bit 0.
  - `in_ready` is high only during the parity beat while busy.

Source files
------------

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the bit-stream pattern detectors.
// Accepts WIDTH-bit words on a valid/ready handshake and emits them MSB first, one bit
// per clock, with ser_valid marking real data bits. Back-to-back words stream gap-free.
// Optional feature: define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to
// every frame (frame becomes WIDTH+1 bits).
module bit_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
`ifdef BIT_SERIALIZER_PARITY_EN
    StShift = 2'd1,
    StParity = 2'd2
`else
    StShift = 2'd1
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_beat;
  logic              accept;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic              par_q, par_d;
`endif

  assign last_beat = (cnt_q == CntW'(WIDTH - 1));
  assign accept    = in_valid & in_ready;

  // Ready decode: depends only on registered state and reset, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StIdle:   in_ready = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
        StShift:  in_ready = 1'b0;
        StParity: in_ready = 1'b1;
`else
        // Last data beat doubles as the accept slot so frames abut.
        StShift:  in_ready = last_beat;
`endif
        default:  in_ready = 1'b0;
      endcase
    end
  end

  // Next-state, datapath update and serial output decode.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_d     = par_q;
`endif
    ser_out   = IDLE_LEVEL;
    ser_valid = 1'b0;
    busy      = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StShift;
          shreg_d = in_data;
          cnt_d   = '0;
`ifdef BIT_SERIALIZER_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      StShift: begin
        ser_valid = 1'b1;
        ser_out   = shreg_q[WIDTH-1];
        shreg_d   = shreg_q << 1;
        cnt_d     = cnt_q + CntW'(1);
        if (last_beat) begin
          // Clear rather than increment so cnt never reaches WIDTH.
          cnt_d = '0;
`ifdef BIT_SERIALIZER_PARITY_EN
          state_d = StParity;
`else
          if (accept) begin
            shreg_d = in_data;
          end else begin
            state_d = StIdle;
          end
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      StParity: begin
        ser_valid = 1'b1;
        ser_out   = par_q;
        if (accept) begin
          state_d = StShift;
          shreg_d = in_data;
          cnt_d   = '0;
          par_d   = ^in_data;
        end else begin
          state_d = StIdle;
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset; reset beats any accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer. The reference model is a queue of bits still owed on the
// serial line: accepted words append their frame, every clock pops one bit.
module tb_bit_serializer;

  localparam int unsigned W     = 8;
  localparam logic        IDLEV = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int unsigned F = W + 1;
`else
  localparam int unsigned F = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         busy;

  int tests = 0;
  int fails = 0;

  bit   exp_q[$];
  logic [3:0] obs_vec;  // {ser_out, ser_valid, in_ready, busy}
  logic [3:0] exp_vec;
  logic       last_accept;

  bit_serializer #(
    .WIDTH     (W),
    .IDLE_LEVEL(IDLEV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, sample outputs and model expectation at negedge,
  // then advance the model across the rising edge.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r);
    logic rdy;
    in_valid = v;
    in_data  = d;
    reset    = r;
    @(negedge clk);
    rdy     = !r && (exp_q.size() <= 1);
    exp_vec = {(exp_q.size() > 0) ? logic'(exp_q[0]) : IDLEV, exp_q.size() > 0, rdy,
               exp_q.size() > 0};
    obs_vec = {ser_out, ser_valid, in_ready, busy};
    last_accept = v && rdy;
    if (r) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (last_accept) begin
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef BIT_SERIALIZER_PARITY_EN
        exp_q.push_back(^d);
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cyc(1'b0, '0, 1'b1);
    tests++;
    if (obs_vec !== exp_vec) begin
      fails++;
      $display("FAIL reset_hold: out/valid/ready/busy=%b required %b", obs_vec, exp_vec);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, $urandom, 1'b0);
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL reset_idle cyc %0d: out/valid/ready/busy=%b required %b",
                 i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_single;
    logic [3:0] win;
    logic [7:0] got;
    int nbits;
    int hits;
    win = '0; got = '0; nbits = 0; hits = 0;
    for (int i = 0; i < F + 4; i++) begin
      cyc(i == 0, 8'hB0, 1'b0);
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL single cyc %0d: out/valid/ready/busy=%b required %b",
                 i, obs_vec, exp_vec);
      end
      if (obs_vec[2]) begin
        win = {win[2:0], obs_vec[3]};
        if (nbits < 8) got = {got[6:0], obs_vec[3]};
        nbits++;
        if (nbits >= 4 && win == 4'b1011) hits++;
      end
    end
    tests++;
    if (got !== 8'hB0 || nbits != F) begin
      fails++;
      $display("FAIL single_frame: got %h in %0d bits required b0 in %0d bits", got, nbits, F);
    end
    tests++;
    if (hits != 1) begin
      fails++;
      $display("FAIL single_detect: 1011 hits %0d required 1", hits);
    end
  endtask

  task automatic test_back_to_back;
    int wait_cyc;
    int vcount;
    bit seen_gap;
    bit started;
    bit done;
    wait_cyc = 0; vcount = 0; seen_gap = 0; started = 0; done = 0;
    for (int i = 0; i < 2 * F + 6; i++) begin
      if (i == 0) cyc(1'b1, 8'h0B, 1'b0);
      else if (!done) cyc(1'b1, 8'hC5, 1'b0);
      else cyc(1'b0, $urandom, 1'b0);
      if (i > 0 && !done) begin
        if (last_accept) done = 1;
        else wait_cyc++;
      end
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL b2b cyc %0d: out/valid/ready/busy=%b required %b", i, obs_vec, exp_vec);
      end
      if (obs_vec[2]) begin
        if (started && seen_gap) seen_gap = 1;
        started = 1;
        vcount++;
      end else if (started && vcount < 2 * F) begin
        seen_gap = 1;
      end
    end
    tests++;
    if (!done || wait_cyc != F - 1) begin
      fails++;
      $display("FAIL b2b_accept: second word taken after %0d cycles (taken=%0d) required %0d",
               wait_cyc, done, F - 1);
    end
    tests++;
    if (vcount != 2 * F || seen_gap) begin
      fails++;
      $display("FAIL b2b_contig: %0d valid cycles gap=%0d required %0d gap=0",
               vcount, seen_gap, 2 * F);
    end
  endtask

  task automatic test_ignore_data;
    for (int i = 0; i < 3 * F + 2 + F + 3; i++) begin
      cyc(i < 3 * F + 2, $urandom, 1'b0);
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL ignore_data cyc %0d: out/valid/ready/busy=%b required %b",
                 i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_mid_reset;
    int late_valid;
    late_valid = 0;
    // Accept, then four beats show bits 7..4; reset lands while bit 3 is on the line.
    for (int i = 0; i < 5; i++) begin
      cyc(i == 0, 8'hFF, 1'b0);
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL mid_reset_pre cyc %0d: out/valid/ready/busy=%b required %b",
                 i, obs_vec, exp_vec);
      end
    end
    cyc(1'b0, '0, 1'b1);
    tests++;
    if (obs_vec !== exp_vec) begin
      fails++;
      $display("FAIL mid_reset_hit: out/valid/ready/busy=%b required %b", obs_vec, exp_vec);
    end
    for (int i = 0; i < F; i++) begin
      cyc(1'b0, '0, 1'b0);
      if (obs_vec[2]) late_valid++;
      tests++;
      if (obs_vec !== {IDLEV, 3'b010}) begin
        fails++;
        $display("FAIL mid_reset_after cyc %0d: out/valid/ready/busy=%b required %b",
                 i, obs_vec, {IDLEV, 3'b010});
      end
    end
    tests++;
    if (late_valid != 0) begin
      fails++;
      $display("FAIL mid_reset_leak: %0d bits after reset required 0", late_valid);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) != 0, $urandom, ($urandom % 60) == 0);
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++;
        $display("FAIL random cyc %0d: out/valid/ready/busy=%b required %b",
                 i, obs_vec, exp_vec);
      end
    end
    cyc(1'b0, '0, 1'b1);
  endtask

`ifdef BIT_SERIALIZER_PARITY_EN
  task automatic test_parity;
    logic [8:0] got;
    logic [8:0] want;
    logic [7:0] words [2];
    words[0] = 8'h07;
    words[1] = 8'h03;
    for (int k = 0; k < 2; k++) begin
      got  = '0;
      want = (k == 0) ? 9'b0000_0111_1 : 9'b0000_0011_0;
      for (int i = 0; i < F + 3; i++) begin
        cyc(i == 0, words[k], 1'b0);
        tests++;
        if (obs_vec !== exp_vec) begin
          fails++;
          $display("FAIL parity w%0d cyc %0d: out/valid/ready/busy=%b required %b",
                   k, i, obs_vec, exp_vec);
        end
        if (obs_vec[2]) got = {got[7:0], obs_vec[3]};
      end
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL parity_frame w%0d: got %b required %b", k, got, want);
      end
    end
  endtask
`endif

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    reset    = 1'b1;
    cyc(1'b0, '0, 1'b1);
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_data();
    test_mid_reset();
`ifdef BIT_SERIALIZER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
